fifo_burst_writer: RTL and testbench
====================================

# fifo_burst_writer

Write-side burst source for the dual-clock FIFO, running in the 400 MHz write domain. On a start pulse it pushes a programmable-length burst of arithmetic-sequence words into the FIFO through the W_INC/WDATA/WFULL handshake. It holds off while the FIFO is full and reports completion, stall count and an XOR checksum. The read side uses that checksum to confirm the burst arrived intact.

## Interface
- DATA_WIDTH, 8, FIFO word width
- LEN_WIDTH, 5, width of BURST_LEN and SENT_CNT; maximum burst is 2^LEN_WIDTH-1 words
- STALL_WIDTH, 8, width of the saturating STALL_CNT
- WCLK  in  1  write-domain clock; all logic on the rising edge
- W_RST  in  1  asynchronous active-low reset
- START  in  1  burst request, sampled only in IDLE
- ABORT  in  1  terminates an active burst
- BURST_LEN  in  LEN_WIDTH  words in the burst, captured with START
- SEED  in  DATA_WIDTH  first data word, captured with START
- STEP  in  DATA_WIDTH  increment between words, captured with START
- WFULL  in  1  FIFO full flag, already in the WCLK domain
- W_INC  out  1  write request to the FIFO
- WDATA  out  DATA_WIDTH  write data to the FIFO
- BUSY  out  1  burst in progress
- DONE  out  1  one-cycle completion pulse
- ABORTED  out  1  qualifies DONE: burst ended by ABORT
- SENT_CNT  out  LEN_WIDTH  words accepted in the current or last burst
- STALL_CNT  out  STALL_WIDTH  cycles with W_INC=1 and WFULL=1, saturating
- CHECKSUM  out  DATA_WIDTH  XOR of all accepted words

## Operation
- **Word acceptance:** a word is accepted on a WCLK edge when W_INC=1 and WFULL=0. This matches the FIFO's write rule.
- **States:** IDLE, SEND, FIN.
- **IDLE, START=1, BURST_LEN≠0:**
  - capture LEN/SEED/STEP
  - clear SENT_CNT, STALL_CNT and CHECKSUM
  - go to SEND with W_INC=1 and WDATA=SEED
- **IDLE, START=1, BURST_LEN=0:** go to FIN. No write occurs, and counters and checksum are cleared.
- **SEND, word accepted:**
  - SENT_CNT++
  - CHECKSUM ^= WDATA
  - WDATA += STEP, modulo 2^DATA_WIDTH
  - if SENT_CNT+1 equals the captured LEN: W_INC=0 and go to FIN
- **SEND, WFULL=1:** W_INC and WDATA hold, and STALL_CNT++ saturates at all-ones.
- **SEND, ABORT=1:**
  - ABORT has priority over acceptance, so the word presented that cycle is not counted; the FIFO may still write it.
  - W_INC=0, ABORTED=1, go to FIN.
- **FIN:** DONE=1 for exactly one cycle, then IDLE.
- **Ignored inputs:** START outside IDLE and ABORT outside SEND.
- **Output hold:** ABORTED, SENT_CNT, STALL_CNT and CHECKSUM hold until the next accepted START.
- **BUSY:** equals 1 exactly in SEND.

## Timing
- **Registered outputs:** all outputs are registered; there is no combinational path from input to output.
- **Reset values:** W_RST low asynchronously forces
  - IDLE
  - W_INC=0, WDATA=0, BUSY=0, DONE=0, ABORTED=0
  - SENT_CNT=0, STALL_CNT=0, CHECKSUM=0
- **Reset mid-burst:** reset during SEND drops W_INC immediately and produces no DONE.
- **START latency:** START sampled at edge k gives W_INC=1 and WDATA=SEED in the cycle after edge k.
- **Throughput:** one word per WCLK cycle while WFULL=0.
- **Burst length:** a burst of N words with S stall cycles takes N+S cycles in SEND.
- **Completion:**
  - DONE is high in the cycle after the last acceptance edge.
  - BUSY and DONE are never high together.
  - The earliest next START is sampled while DONE=1 is ignored; the next START is accepted in IDLE, one cycle later.
- **Simultaneous events:**
  - WFULL rising in the same cycle as the final word: that word is not accepted; it is held and retried.
  - ABORT together with WFULL: the abort wins and does not count a stall.

## Structure
- **Package fifo_burst_pkg:** the state enum typedef (IDLE/SEND/FIN) and default width localparams shared with the read-side checker.
- **Sub-module sat_counter:** parameterised width, with increment enable and synchronous clear. It is instantiated for STALL_CNT.
- **Main FSM:** the data path (WDATA adder, checksum XOR, SENT_CNT) stays in the main FSM module.

## Test plan
- **Basic burst:** LEN=3, SEED=0x01, STEP=0xE8, WFULL=0 → WDATA 01, E9, D1 on consecutive cycles; then DONE=1, SENT_CNT=3, CHECKSUM=0x39, STALL_CNT=0.
- **Stall:** LEN=4, SEED=0x10, STEP=0x01, WFULL=1 for 5 cycles on word 2 → WDATA holds 0x11 throughout; all four words 10..13 accepted; STALL_CNT=5; BUSY high 9 cycles.
- **Abort:** LEN=10, SEED=0xA0, STEP=0x02, ABORT asserted after 3 acceptances → W_INC=0 next cycle, DONE=1 with ABORTED=1, SENT_CNT=3, CHECKSUM=0xA0^0xA2^0xA4=0xA6.
- **Zero and maximum length:** LEN=0 → DONE one cycle after START, W_INC never high. LEN=31, SEED=0xF0, STEP=0x10 → data wraps F0, 00, 10, …; SENT_CNT=31.
- **Ignored start and reset:**
  - START pulsed while BUSY → no effect on the active burst.
  - W_RST low mid-burst → W_INC=0 and all counters 0 without waiting for a clock; no DONE.
- **Checksum end-to-end:** writer drives the FIFO at 2.5 ns; a 25 ns read domain drains it → read-side XOR equals CHECKSUM for a 10-word burst.

Source files
------------

// File: rtl/fifo_burst_pkg.sv
// Shared types and default widths for the dual-clock FIFO burst writer and read-side checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_burst_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_LEN_WIDTH   = 5;
    localparam int DEF_STALL_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } burst_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: count updates on the clock edge after inc/clr.
// Backpressure: none; it holds at all-ones once saturated.
//
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to zero
//   inc        : increment enable
//   cnt        : current count
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/fifo_burst_writer.sv
// Write-side burst source: pushes an arithmetic-sequence burst into the FIFO, tracking stalls and an XOR checksum.
// Latency: first word is presented the cycle after START; DONE follows the last accepted word by one cycle.
// Backpressure: WFULL holds the presented word in place, which is retried at one word per cycle once it drops.
//
// Ports:
//   wclk, w_rst        : write clock, async active-low reset
//   start, abort       : burst request (IDLE only), burst terminate (SEND only)
//   burst_len/seed/step: burst parameters captured with an accepted start
//   wfull              : FIFO full flag (already in wclk domain)
//   w_inc, wdata       : FIFO write request and data
//   busy, done, aborted: status; done is a one-cycle pulse qualified by aborted
//   sent_cnt, stall_cnt, checksum : per-burst statistics, held until the next start
module fifo_burst_writer
    import fifo_burst_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
    parameter int STALL_WIDTH = DEF_STALL_WIDTH
) (
    input  logic                   wclk,
    input  logic                   w_rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [LEN_WIDTH-1:0]   burst_len,
    input  logic [DATA_WIDTH-1:0]  seed,
    input  logic [DATA_WIDTH-1:0]  step,
    input  logic                   wfull,
    output logic                   w_inc,
    output logic [DATA_WIDTH-1:0]  wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [LEN_WIDTH-1:0]   sent_cnt,
    output logic [STALL_WIDTH-1:0] stall_cnt,
    output logic [DATA_WIDTH-1:0]  checksum
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    burst_state_t state, state_nxt;

    logic [LEN_WIDTH-1:0]  len_q;
    logic [DATA_WIDTH-1:0] step_q;
    logic                  launch;
    logic                  last_word;

    assign launch    = (state == IDLE) && start;
    // W_INC is always high in SEND, so the word is accepted whenever WFULL is low.
    assign last_word = ((sent_cnt + LEN_ONE) == len_q);

    // State register
    always_ff @(posedge wclk or negedge w_rst) begin
        if (!w_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (burst_len != '0) ? SEND : FIN;
                end
            end
            SEND: begin
                // Abort beats acceptance: the word on the bus this cycle is not counted.
                if (abort) begin
                    state_nxt = FIN;
                end else if (!wfull && last_word) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: driven straight from the state flops, so no input-to-output path.
    always_comb begin
        w_inc = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            SEND: begin
                w_inc = 1'b1;
                busy  = 1'b1;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    // Data path: burst parameters, write data generator, accepted-word count and checksum.
    always_ff @(posedge wclk or negedge w_rst) begin
        if (!w_rst) begin
            len_q    <= '0;
            step_q   <= '0;
            wdata    <= '0;
            sent_cnt <= '0;
            checksum <= '0;
            aborted  <= 1'b0;
        end else if (launch) begin
            len_q    <= burst_len;
            step_q   <= step;
            wdata    <= seed;
            sent_cnt <= '0;
            checksum <= '0;
            aborted  <= 1'b0;
        end else if (state == SEND) begin
            if (abort) begin
                aborted <= 1'b1;
            end else if (!wfull) begin
                sent_cnt <= sent_cnt + LEN_ONE;
                checksum <= checksum ^ wdata;
                wdata    <= wdata + step_q;
            end
        end
    end

    // An aborting cycle is not a stall even if WFULL is high.
    sat_counter #(
        .WIDTH (STALL_WIDTH)
    ) u_stall_cnt (
        .clk   (wclk),
        .rst_n (w_rst),
        .clr   (launch),
        .inc   ((state == SEND) && wfull && !abort),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_fifo_burst_writer.sv
`timescale 1ns/100ps
module tb_fifo_burst_writer;

    logic       wclk = 1'b0;
    logic       w_rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       wfull = 1'b0;
    logic [4:0] burst_len = '0;
    logic [7:0] seed = '0;
    logic [7:0] step = '0;

    logic       w_inc;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [4:0] sent_cnt;
    logic [7:0] stall_cnt;
    logic [7:0] checksum;

    int vectors = 0;
    int miscompares = 0;

    always #1.25 wclk = ~wclk;

    fifo_burst_writer #(
        .DATA_WIDTH  (8),
        .LEN_WIDTH   (5),
        .STALL_WIDTH (8)
    ) dut (
        .wclk      (wclk),
        .w_rst     (w_rst),
        .start     (start),
        .abort     (abort),
        .burst_len (burst_len),
        .seed      (seed),
        .step      (step),
        .wfull     (wfull),
        .w_inc     (w_inc),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .sent_cnt  (sent_cnt),
        .stall_cnt (stall_cnt),
        .checksum  (checksum)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: word i of a burst is seed + i*step (mod 256); a word is accepted in any
    // SEND cycle with WFULL low and ABORT low; stalls are SEND cycles with WFULL high and
    // no ABORT, saturating at 255; the checksum is the XOR of accepted words.
    task automatic run_burst(input int len, input int sd, input int st, input int full_pct,
                             input int abort_at, input int stall_word, input int stall_run,
                             input bit poke);
        int         acc = 0;
        int         raw_stalls = 0;
        int         busy_seen = 0;
        int         cyc = 0;
        int         stall_left;
        logic [7:0] xr = '0;
        logic [7:0] word;
        bit         ab = 1'b0;
        bit         ended = 1'b0;
        stall_left = stall_run;
        @(negedge wclk);
        start = 1'b1; burst_len = 5'(len); seed = 8'(sd); step = 8'(st);
        @(negedge wclk);
        // Scramble the parameter inputs: the burst must run from the captured copies.
        burst_len = 5'($urandom); seed = 8'($urandom); step = 8'($urandom);
        while (!ended) begin
            abort = 1'b0; wfull = 1'b0; start = 1'b0;
            if (cyc >= 2000) begin
                check("done_timeout", 32'd0, 32'd1);
                ended = 1'b1;
            end else if (done) begin
                ended = 1'b1;
                check("done_busy", busy, 0);
                check("done_winc", w_inc, 0);
                check("aborted", aborted, ab);
                check("sent_cnt", sent_cnt, acc);
                check("stall_cnt", stall_cnt, (raw_stalls > 255) ? 255 : raw_stalls);
                check("checksum", checksum, xr);
                check("busy_cycles", busy_seen, acc + raw_stalls + (ab ? 1 : 0));
                if (!ab) check("words_before_done", acc, len);
            end else begin
                word = 8'(sd + acc * st);
                check("busy", busy, 1);
                check("w_inc", w_inc, 1);
                check("wdata", wdata, word);
                if (busy) busy_seen++;
                if (poke && cyc == 2) begin
                    start = 1'b1; burst_len = 5'd7; seed = 8'h55; step = 8'h03;
                end
                if (abort_at >= 0 && acc == abort_at) begin
                    abort = 1'b1;
                    ab = 1'b1;
                    wfull = (full_pct > 0);
                end else if (acc == stall_word && stall_left > 0) begin
                    wfull = 1'b1;
                    stall_left--;
                end else begin
                    wfull = ($urandom_range(99) < full_pct);
                end
                if (!abort) begin
                    if (wfull) raw_stalls++;
                    else begin
                        acc++;
                        xr ^= word;
                    end
                end
                cyc++;
                @(negedge wclk);
            end
        end
    endtask

    initial begin
        int len;
        int ab_at;
        int seen;

        // Reset values
        #3;
        check("rst_winc", w_inc, 0);
        check("rst_wdata", wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_sent", sent_cnt, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_csum", checksum, 0);
        @(negedge wclk);
        w_rst = 1'b1;
        @(negedge wclk);

        // Basic burst: 01, E9, D1 -> checksum 39
        run_burst(3, 8'h01, 8'hE8, 0, -1, -1, 0, 1'b0);
        check("basic_csum_const", checksum, 32'h39);
        // Stall: five WFULL cycles while word 0x11 is presented
        run_burst(4, 8'h10, 8'h01, 0, -1, 1, 5, 1'b0);
        check("stall_const", stall_cnt, 32'd5);
        // Abort after three acceptances
        run_burst(10, 8'hA0, 8'h02, 0, 3, -1, 0, 1'b0);
        check("abort_csum_const", checksum, 32'hA6);
        // START while DONE is high is ignored
        start = 1'b1; burst_len = 5'd5;
        @(negedge wclk);
        check("start_in_fin_busy", busy, 0);
        check("start_in_fin_done", done, 0);
        start = 1'b0;
        @(negedge wclk);
        check("start_in_fin_idle", busy, 0);
        // Zero and maximum length
        run_burst(0, 8'h12, 8'h34, 0, -1, -1, 0, 1'b0);
        run_burst(31, 8'hF0, 8'h10, 0, -1, -1, 0, 1'b0);
        // START pulsed mid-burst, with random stalls
        run_burst(10, 8'h21, 8'h0B, 30, -1, -1, 0, 1'b1);
        // Abort together with WFULL
        run_burst(12, 8'h40, 8'h05, 40, 5, -1, 0, 1'b0);
        // Stall counter saturation
        run_burst(31, 8'h5A, 8'h07, 95, -1, -1, 0, 1'b0);
        check("stall_saturated", stall_cnt, 32'd255);

        // Randomized bursts
        for (int i = 0; i < 16; i++) begin
            len = $urandom_range(31);
            ab_at = -1;
            if (len > 0 && $urandom_range(3) == 0) ab_at = $urandom_range(len - 1);
            run_burst(len, $urandom_range(255), $urandom_range(255), $urandom_range(60),
                      ab_at, -1, 0, bit'($urandom_range(1)));
        end

        // Reset mid-burst: outputs clear without a clock edge and no DONE follows
        @(negedge wclk);
        start = 1'b1; burst_len = 5'd20; seed = 8'h03; step = 8'h01;
        @(negedge wclk);
        start = 1'b0;
        repeat (4) @(negedge wclk);
        check("pre_rst_busy", busy, 1);
        #0.3 w_rst = 1'b0;
        #0.2;
        check("mid_rst_winc", w_inc, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sent", sent_cnt, 0);
        check("mid_rst_stall", stall_cnt, 0);
        check("mid_rst_csum", checksum, 0);
        check("mid_rst_wdata", wdata, 0);
        @(negedge wclk);
        w_rst = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge wclk);
            if (done || busy) seen++;
        end
        check("no_done_after_rst", seen, 0);

        // Normal operation resumes after reset
        run_burst(10, 8'h3C, 8'h11, 20, -1, -1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
